// File: rtl/br_predictor_pkg.sv
// Shared types and constants for the fetch-side branch predictor.
// Holds the counter encoding and the saturating counter update rule.
package br_predictor_pkg;

  localparam int DEF_PC_SZ       = 32;
  localparam int DEF_BTB_ENTRIES = 64;

  typedef logic [1:0] btb_ctr_t;

  localparam btb_ctr_t CTR_SN = 2'd0;
  localparam btb_ctr_t CTR_WT = 2'd2;
  localparam btb_ctr_t CTR_ST = 2'd3;

  // 2-bit saturating step toward the resolved direction
  function automatic btb_ctr_t ctr_step(input btb_ctr_t ctr, input logic taken);
    btb_ctr_t nxt;
    if (taken) begin
      nxt = (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    end else begin
      nxt = (ctr == CTR_SN) ? CTR_SN : ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/btb_ram.sv
// BTB storage: one registered read port (read-before-write) for fetch, one write port,
// and a combinational metadata probe at the write index used to train counters.
module btb_ram
  import br_predictor_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = 6,
  parameter int TAG_W   = 25,
  parameter int PC_SZ   = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [PC_SZ-1:0] rd_target,
  output btb_ctr_t         rd_ctr,
  input  logic [IDX_W-1:0] pr_idx,
  output logic             pr_valid,
  output logic [TAG_W-1:0] pr_tag,
  output btb_ctr_t         pr_ctr,
  input  logic             wr_en,
  input  logic             wr_target_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [PC_SZ-1:0] wr_target,
  input  btb_ctr_t         wr_ctr
);

  logic [ENTRIES-1:0] valid_r;
  logic [TAG_W-1:0]   tag_mem_r    [ENTRIES];
  btb_ctr_t           ctr_mem_r    [ENTRIES];
  logic [PC_SZ-1:0]   target_mem_r [ENTRIES];

  logic             rd_valid_r;
  logic [TAG_W-1:0] rd_tag_r;
  logic [PC_SZ-1:0] rd_target_r;
  btb_ctr_t         rd_ctr_r;

  // Valid bits live in flops so reset and flush clear every entry in one cycle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_r <= '0;
    end else if (flush) begin
      valid_r <= '0;
    end else if (wr_en) begin
      valid_r[wr_idx] <= 1'b1;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Entry payload write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem_r[wr_idx] <= wr_tag;
      ctr_mem_r[wr_idx] <= wr_ctr;
    end
    if (wr_en && wr_target_en) begin
      target_mem_r[wr_idx] <= wr_target;
    end
  end

  // Registered read; sees the contents from before any same-edge write or flush
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_valid_r  <= 1'b0;
      rd_tag_r    <= '0;
      rd_target_r <= '0;
      rd_ctr_r    <= CTR_SN;
    end else begin
      rd_valid_r  <= valid_r[rd_idx];
      rd_tag_r    <= tag_mem_r[rd_idx];
      rd_target_r <= target_mem_r[rd_idx];
      rd_ctr_r    <= ctr_mem_r[rd_idx];
    end
  end

  assign rd_valid  = rd_valid_r;
  assign rd_tag    = rd_tag_r;
  assign rd_target = rd_target_r;
  assign rd_ctr    = rd_ctr_r;

  assign pr_valid = valid_r[pr_idx];
  assign pr_tag   = tag_mem_r[pr_idx];
  assign pr_ctr   = ctr_mem_r[pr_idx];

endmodule

// File: rtl/br_predictor.sv
// Direct-mapped BTB branch predictor: one-cycle lookup for fetch, training from
// resolved EXE outcomes, and a registered mispredict/redirect to PC select.
module br_predictor
  import br_predictor_pkg::*;
#(
  parameter int BTB_ENTRIES = DEF_BTB_ENTRIES,
  parameter int PC_SZ       = DEF_PC_SZ
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             pred_valid_in,
  input  logic [PC_SZ-1:0] pred_pc_in,
  output logic             pred_valid_out,
  output logic             pred_hit_out,
  output logic             pred_taken_out,
  output logic [PC_SZ-1:0] pred_target_out,
  input  logic             upd_valid_in,
  input  logic [PC_SZ-1:0] upd_pc_in,
  input  logic             upd_is_br_in,
  input  logic             upd_taken_in,
  input  logic [PC_SZ-1:0] upd_target_in,
  input  logic [PC_SZ-1:0] upd_no_br_pc_in,
  input  logic             upd_pred_taken_in,
  input  logic [PC_SZ-1:0] upd_pred_target_in,
  input  logic             flush_in,
  output logic             mispredict_out,
  output logic [PC_SZ-1:0] redirect_pc_out
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = PC_SZ - IDX_W - 1;

  // Bit 0 of a PC never selects an entry: instructions are at least 16-bit aligned
  logic [IDX_W-1:0] lk_idx_s;
  logic [TAG_W-1:0] lk_tag_s;
  logic [IDX_W-1:0] up_idx_s;
  logic [TAG_W-1:0] up_tag_s;

  assign lk_idx_s = pred_pc_in[IDX_W:1];
  assign lk_tag_s = pred_pc_in[PC_SZ-1:IDX_W+1];
  assign up_idx_s = upd_pc_in[IDX_W:1];
  assign up_tag_s = upd_pc_in[PC_SZ-1:IDX_W+1];

  logic             rd_valid_s;
  logic [TAG_W-1:0] rd_tag_s;
  logic [PC_SZ-1:0] rd_target_s;
  btb_ctr_t         rd_ctr_s;
  logic             pr_valid_s;
  logic [TAG_W-1:0] pr_tag_s;
  btb_ctr_t         pr_ctr_s;

  logic     up_hit_s;
  logic     wr_en_s;
  logic     wr_target_en_s;
  btb_ctr_t wr_ctr_s;

  logic             mis_s;
  logic [PC_SZ-1:0] redirect_s;

  logic             pred_valid_r;
  logic [TAG_W-1:0] pred_tag_r;
  logic             mispredict_r;
  logic [PC_SZ-1:0] redirect_r;
  logic             lk_hit_s;
  logic             unused_bits_s;

  btb_ram #(
    .ENTRIES (BTB_ENTRIES),
    .IDX_W   (IDX_W),
    .TAG_W   (TAG_W),
    .PC_SZ   (PC_SZ)
  ) u_btb_ram (
    .clk          (clk_in),
    .reset_n      (reset_in),
    .flush        (flush_in),
    .rd_idx       (lk_idx_s),
    .rd_valid     (rd_valid_s),
    .rd_tag       (rd_tag_s),
    .rd_target    (rd_target_s),
    .rd_ctr       (rd_ctr_s),
    .pr_idx       (up_idx_s),
    .pr_valid     (pr_valid_s),
    .pr_tag       (pr_tag_s),
    .pr_ctr       (pr_ctr_s),
    .wr_en        (wr_en_s),
    .wr_target_en (wr_target_en_s),
    .wr_idx       (up_idx_s),
    .wr_tag       (up_tag_s),
    .wr_target    (upd_target_in),
    .wr_ctr       (wr_ctr_s)
  );

  // Training decision; reset and flush both drop the write
  always_comb begin
    up_hit_s       = pr_valid_s && (pr_tag_s == up_tag_s);
    wr_en_s        = 1'b0;
    wr_target_en_s = 1'b0;
    wr_ctr_s       = pr_ctr_s;
    if (upd_valid_in && reset_in && !flush_in) begin
      if (up_hit_s) begin
        wr_en_s = 1'b1;
        if (upd_is_br_in) begin
          wr_ctr_s       = ctr_step(pr_ctr_s, upd_taken_in);
          wr_target_en_s = upd_taken_in;
        end else begin
          // Unconditional transfers always retarget so changing JALR/xRET targets track
          wr_ctr_s       = CTR_ST;
          wr_target_en_s = 1'b1;
        end
      end else if (upd_taken_in) begin
        wr_en_s        = 1'b1;
        wr_target_en_s = 1'b1;
        wr_ctr_s       = upd_is_br_in ? CTR_WT : CTR_ST;
      end else begin
        wr_en_s = 1'b0;
      end
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Resolution check against the prediction carried down the pipe
  always_comb begin
    mis_s      = (upd_pred_taken_in != upd_taken_in) ||
                 (upd_taken_in && (upd_pred_target_in != upd_target_in));
    redirect_s = upd_taken_in ? upd_target_in : upd_no_br_pc_in;
  end

  // Lookup tracking and registered mispredict pulse; redirect holds between updates
  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      pred_valid_r <= 1'b0;
      pred_tag_r   <= '0;
      mispredict_r <= 1'b0;
      redirect_r   <= '0;
    end else begin
      pred_valid_r <= pred_valid_in;
      pred_tag_r   <= lk_tag_s;
      if (upd_valid_in) begin
        mispredict_r <= mis_s;
        redirect_r   <= redirect_s;
      end else begin
        mispredict_r <= 1'b0;
        redirect_r   <= redirect_r;
      end
    end
  end

  assign lk_hit_s        = pred_valid_r && rd_valid_s && (rd_tag_s == pred_tag_r);
  assign pred_valid_out  = pred_valid_r;
  assign pred_hit_out    = lk_hit_s;
  assign pred_taken_out  = lk_hit_s && rd_ctr_s[1];
  assign pred_target_out = lk_hit_s ? rd_target_s : {PC_SZ{1'b0}};
  assign mispredict_out  = mispredict_r;
  assign redirect_pc_out = redirect_r;

  assign unused_bits_s = ^{pred_pc_in[0], upd_pc_in[0], rd_ctr_s[0]};

endmodule
